// File: rtl/ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and encodings for the multicycle ARM controller:
//               FSM state enum, ALU control codes, condition codes, data-
//               processing commands and datapath mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // ARM condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Data-processing commands (instr[24:21])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_SBC = 4'b0110;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Datapath mux encodings
  localparam logic [1:0] RES_ALUOUT  = 2'd0;
  localparam logic [1:0] RES_DATA    = 2'd1;
  localparam logic [1:0] RES_ALURES  = 2'd2;
  localparam logic [1:0] SRCA_RN     = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_ALUOUT = 2'd2;
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : Combinational ARM condition evaluation of cond against the
//               NZCV flag vector (N in the MSB). Code 1111 evaluates false.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_unit
  import ctrl_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags[FLAG_W-1:FLAG_W-4];

  // Decode every condition code against the current flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = ~(n ^ v);
      COND_LT: cond_ex = n ^ v;
      COND_GT: cond_ex = ~z & ~(n ^ v);
      COND_LE: cond_ex = z | (n ^ v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle ARM control unit. Sequences fetch/decode/execute/
//               memory/writeback, owns the NZCV register and handshakes with
//               a variable-latency memory (mem_req/mem_ready).
//               Optional: define CTRL_RETIRE_COUNT_EN to add the 'retired'
//               instruction counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int FLAG_W    = 4,
  parameter int ALU_CTL_W = 3
`ifdef CTRL_RETIRE_COUNT_EN
  ,
  parameter int CNT_W     = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  input  logic [3:0]           cond,
  input  logic [FLAG_W-1:0]    alu_flags,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [1:0]           reg_src,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 shift,
  output logic                 swap,
  output logic                 carry,
  output logic [FLAG_W-1:0]    flags
`ifdef CTRL_RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]     retired
`endif
);

  state_t     state;
  logic       armed;      // low for the first cycle after reset: no request was outstanding yet
  logic       cond_ex;
  logic       cond_ex_q;
  logic [3:0] cmd;
  logic [2:0] dec_ctl;
  logic       dec_swap, dec_shift, dec_valid, dec_arith, no_write;

  assign cmd   = funct[4:1];
  assign carry = flags[FLAG_W-3];

  cond_unit #(.FLAG_W(FLAG_W)) u_cond (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  // Data-processing command decode; unsupported commands write nothing
  always_comb begin
    dec_ctl   = ALU_ADD;
    dec_swap  = 1'b0;
    dec_shift = 1'b0;
    dec_valid = 1'b1;
    dec_arith = 1'b0;
    no_write  = 1'b0;
    case (cmd)
      CMD_ADD: dec_arith = 1'b1;
      CMD_ADC: dec_arith = 1'b1;
      CMD_SUB: begin dec_ctl = ALU_SUB; dec_arith = 1'b1; end
      CMD_SBC: begin dec_ctl = ALU_SUB; dec_arith = 1'b1; end
      CMD_RSB: begin dec_ctl = ALU_SUB; dec_arith = 1'b1; dec_swap = 1'b1; end
      CMD_AND: dec_ctl = ALU_AND;
      CMD_ORR: dec_ctl = ALU_ORR;
      CMD_EOR: dec_ctl = ALU_EOR;
      CMD_CMP: begin dec_ctl = ALU_SUB; dec_arith = 1'b1; no_write = 1'b1; end
      CMD_TST: begin dec_ctl = ALU_AND; no_write = 1'b1; end
      CMD_MOV: dec_shift = 1'b1;
      default: begin dec_valid = 1'b0; no_write = 1'b1; end
    endcase
  end

  // Instruction sequencer, condition latch and flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      armed     <= 1'b0;
      cond_ex_q <= 1'b0;
      flags     <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        FETCH:    if (armed && mem_ready) state <= DECODE;
        DECODE: begin
          cond_ex_q <= cond_ex;
          case (op)
            2'b01:   state <= MEMADR;
            2'b00:   state <= funct[5] ? EXECI : EXECR;
            2'b10:   state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:   state <= funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR, EXECI: begin
          if (funct[0] && cond_ex_q && dec_valid) begin
            flags[FLAG_W-1:FLAG_W-2] <= alu_flags[FLAG_W-1:FLAG_W-2];
            if (dec_arith) flags[FLAG_W-3:FLAG_W-4] <= alu_flags[FLAG_W-3:FLAG_W-4];
          end
          state <= ALUWB;
        end
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Per-state datapath controls; everything is forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_RN;
    alu_src_b  = SRCB_REG;
    imm_src    = 2'd0;
    reg_src    = 2'd0;
    alu_ctl    = ALU_CTL_W'(ALU_ADD);
    shift      = 1'b0;
    swap       = 1'b0;
    if (reset) begin
      imm_src = op;
      reg_src = {op == 2'b01, op == 2'b10};
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURES;
          ir_write   = armed & mem_ready;
          pc_write   = armed & mem_ready;
        end
        DECODE: begin
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
        end
        MEMADR:   alu_src_b = SRCB_IMM;
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        MEMWB: begin
          result_src = RES_DATA;
          reg_write  = cond_ex_q;
        end
        MEMWRITE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mem_write = cond_ex_q;
        end
        EXECR, EXECI: begin
          alu_src_b = (state == EXECI) ? SRCB_IMM : SRCB_REG;
          alu_ctl   = ALU_CTL_W'(dec_ctl);
          swap      = dec_swap;
          shift     = dec_shift;
        end
        ALUWB: begin
          if (cond_ex_q && !no_write) begin
            if (rd == 4'd15) pc_write  = 1'b1;
            else             reg_write = 1'b1;
          end
        end
        BRANCH: begin
          alu_src_a  = SRCA_ALUOUT;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALURES;
          pc_write   = cond_ex_q;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_RETIRE_COUNT_EN
  logic retire_evt;
  assign retire_evt = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                      ((state == MEMWRITE) && mem_ready) ||
                      ((state == DECODE) && (op == 2'b11));

  // Count every instruction that returns to FETCH, condition-failed or not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          retired <= '0;
    else if (retire_evt) retired <= retired + 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Directed
//               instruction sequences followed by random instructions, each
//               predicted by an instruction-level reference model.
//               Honours CTRL_RETIRE_COUNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, alu_flags;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src;
  logic [2:0] alu_ctl;
  logic       shift, swap, carry;
  logic [3:0] flags;
`ifdef CTRL_RETIRE_COUNT_EN
  logic [31:0] retired;
  int          model_ret;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_flags;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_src(reg_src), .alu_ctl(alu_ctl), .shift(shift), .swap(swap),
    .carry(carry), .flags(flags)
`ifdef CTRL_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM condition semantics: even codes test a base predicate, odd codes invert it
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit base;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] == f[0]);
      default: base = !f[2] && (f[3] == f[0]);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns at the next FETCH
  task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] fn,
                           input logic [3:0] r, input logic [3:0] c, input logic [3:0] af,
                           input int fw, input int mw);
    bit pass, is_ld, is_st, is_dp, is_br, known, writes, arith, exp_swap, exp_shift;
    bit fetched, ended, is_fetch;
    int exp_cyc, exp_rw, exp_pc, exp_mw;
    int cyc, post, req_cnt, tgt, n_ir, n_fpc, n_pc, n_rw, n_mw;
    logic [2:0] exp_ctl, obs_ctl;
    logic [1:0] last_rsrc;
    logic [3:0] exp_flags;
    logic       obs_swap, obs_shift;

    pass  = cond_pass(c, model_flags);
    is_ld = (o == 2'b01) && fn[0];
    is_st = (o == 2'b01) && !fn[0];
    is_dp = (o == 2'b00);
    is_br = (o == 2'b10);
    known = 1; writes = 1; arith = 0; exp_swap = 0; exp_shift = 0; exp_ctl = 3'd0;
    case (fn[4:1])
      4'b0100, 4'b0101: arith = 1;
      4'b0010, 4'b0110: begin exp_ctl = 3'd1; arith = 1; end
      4'b0011: begin exp_ctl = 3'd1; arith = 1; exp_swap = 1; end
      4'b0000: exp_ctl = 3'd2;
      4'b1100: exp_ctl = 3'd3;
      4'b0001: exp_ctl = 3'd4;
      4'b1010: begin exp_ctl = 3'd1; arith = 1; writes = 0; end
      4'b1000: begin exp_ctl = 3'd2; writes = 0; end
      4'b1101: exp_shift = 1;
      default: begin known = 0; writes = 0; end
    endcase
    exp_cyc = fw + (is_ld ? 5 + mw : is_st ? 4 + mw : is_dp ? 4 : is_br ? 3 : 2);
    exp_rw  = ((is_ld && pass) || (is_dp && pass && writes && r != 4'd15)) ? 1 : 0;
    exp_pc  = ((is_dp && pass && writes && r == 4'd15) || (is_br && pass)) ? 1 : 0;
    exp_mw  = (is_st && pass) ? mw + 1 : 0;
    exp_flags = model_flags;
    if (is_dp && fn[0] && pass && known) begin
      exp_flags[3:2] = af[3:2];
      if (arith) exp_flags[1:0] = af[1:0];
    end

    op = o; funct = fn; rd = r; cond = c; alu_flags = af;
    cyc = 0; post = 0; req_cnt = 0; fetched = 0; ended = 0;
    n_ir = 0; n_fpc = 0; n_pc = 0; n_rw = 0; n_mw = 0;
    last_rsrc = 2'd3; obs_ctl = 3'd7; obs_swap = 1'bx; obs_shift = 1'bx;
    for (int k = 0; k < 60; k++) begin
      is_fetch = mem_req && !adr_src;
      if (fetched && is_fetch) begin ended = 1; break; end
      if (mem_req) begin
        tgt = adr_src ? mw : fw;
        if (req_cnt >= tgt) begin mem_ready = 1'b1; req_cnt = 0; end
        else begin mem_ready = 1'b0; req_cnt++; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (is_fetch) begin
        n_ir += int'(ir_write); n_fpc += int'(pc_write);
        if (ir_write) fetched = 1;
      end else begin
        post++;
        n_ir += int'(ir_write); n_pc += int'(pc_write);
        n_rw += int'(reg_write); n_mw += int'(mem_write);
        if (reg_write) last_rsrc = result_src;
        if (post == 2) begin obs_ctl = alu_ctl; obs_swap = swap; obs_shift = shift; end
      end
      cyc++;
      @(negedge clk);
    end

    check({name, ".done"}, 32'(ended), 32'd1);
    check({name, ".cycles"}, cyc, exp_cyc);
    check({name, ".ir_write"}, n_ir, 1);
    check({name, ".fetch_pc"}, n_fpc, 1);
    check({name, ".reg_write"}, n_rw, exp_rw);
    check({name, ".pc_write"}, n_pc, exp_pc);
    check({name, ".mem_write"}, n_mw, exp_mw);
    check({name, ".flags"}, 32'(flags), 32'(exp_flags));
    check({name, ".carry"}, 32'(carry), 32'(exp_flags[1]));
    if (exp_rw == 1) check({name, ".result_src"}, 32'(last_rsrc), is_ld ? 32'd1 : 32'd0);
    if (is_dp) begin
      check({name, ".alu_ctl"}, 32'(obs_ctl), 32'(exp_ctl));
      check({name, ".swap"}, 32'(obs_swap), 32'(exp_swap));
      check({name, ".shift"}, 32'(obs_shift), 32'(exp_shift));
    end
`ifdef CTRL_RETIRE_COUNT_EN
    model_ret++;
    check({name, ".retired"}, retired, model_ret);
`endif
    model_flags = exp_flags;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0;
    cond = 4'hE; alu_flags = 4'd0;

    // Reset holds every strobe and select low
    repeat (2) @(negedge clk); #1;
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.strobes", 32'({reg_write, pc_write, ir_write, mem_write}), 0);
    check("rst.selects", 32'({result_src, alu_src_a, alu_src_b, adr_src}), 0);
    check("rst.flags", 32'(flags), 0);

    // First FETCH requests memory but does not complete in its first cycle
    @(negedge clk); reset = 1'b1; #1;
    check("rel.mem_req", 32'(mem_req), 1);
    check("rel.ir_pc", 32'({ir_write, pc_write}), 0);
    op = 2'b00; funct = 6'b000101; rd = 4'd1; cond = 4'hE; alu_flags = 4'b1111;
    @(negedge clk); #1;
    check("rel2.ir_pc", 32'({ir_write, pc_write}), 32'b11);
    @(negedge clk);           // DECODE
    @(negedge clk); #1;       // EXECR
    check("execr.alu_ctl", 32'(alu_ctl), 1);

    // Abort mid-EXECR: no strobes, flags never updated
    reset = 1'b0; #1;
    check("abort.strobes", 32'({reg_write, pc_write, ir_write, mem_write, mem_req}), 0);
    repeat (2) @(negedge clk);
    check("abort.flags", 32'(flags), 0);
    reset = 1'b1; #1;
    check("abort.rel_req", 32'(mem_req), 1);
    check("abort.rel_ir", 32'(ir_write), 0);
    @(negedge clk);
    model_flags = 4'd0;
`ifdef CTRL_RETIRE_COUNT_EN
    model_ret = 0;
`endif

    // Directed instruction sequences
    run_instr("add",     2'b00, 6'b001000, 4'd3,  4'hE, 4'b0000, 0, 0);
    run_instr("ldr",     2'b01, 6'b011001, 4'd2,  4'hE, 4'b0000, 0, 3);
    run_instr("subs_z",  2'b00, 6'b000101, 4'd4,  4'hE, 4'b0100, 0, 0);
    run_instr("beq_t",   2'b10, 6'b100000, 4'd0,  4'h0, 4'b1011, 0, 0);
    run_instr("subs_nz", 2'b00, 6'b000101, 4'd4,  4'hE, 4'b0000, 1, 0);
    run_instr("beq_f",   2'b10, 6'b100000, 4'd0,  4'h0, 4'b0000, 0, 0);
    run_instr("subs_z2", 2'b00, 6'b000101, 4'd5,  4'hE, 4'b0110, 0, 0);
    run_instr("str_ne",  2'b01, 6'b011000, 4'd6,  4'h1, 4'b0000, 0, 2);
    run_instr("mov_pc",  2'b00, 6'b011010, 4'd15, 4'hE, 4'b0000, 0, 0);
    run_instr("undef",   2'b11, 6'b000000, 4'd0,  4'hE, 4'b0000, 2, 0);

    // Random instructions, including condition-failed and unsupported ones
    for (int i = 0; i < 40; i++) begin
      run_instr("rand", 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
